// File: rtl/eth_rx_pkg.sv
// eth_rx_pkg: shared types and constants for the GMII/UDP receive path.
// Also holds the byte-wide CRC-32 step shared with the transmit FCS logic.
package eth_rx_pkg;
  typedef enum logic [2:0] {
    IDLE, PREAMBLE, ETH_HDR, IP_HDR,
    UDP_HDR, PAYLOAD, TAIL, DROP
  } rx_state_e;

  localparam int ETH_HDR_LEN = 14;
  localparam int IP_HDR_LEN  = 20;
  localparam int UDP_HDR_LEN = 8;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
  localparam logic [7:0]  IP_VER_IHL     = 8'h45;
  localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
  localparam logic [7:0]  SFD_BYTE       = 8'hD5;
  localparam logic [31:0] CRC_INIT       = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY_R     = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE    = 32'hDEBB_20E3;

  function automatic logic [31:0] crc32_step(
    input logic [31:0] crc,
    input logic [7:0]  d
  );
    logic [31:0] c;
    c = crc ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ CRC_POLY_R) : (c >> 1);
    return c;
  endfunction
endpackage

// File: rtl/crc32_d8.sv
// crc32_d8: reflected CRC-32, one byte per cycle, with preset and enable.
// Shared by the receive checker and the transmit FCS generator.
module crc32_d8
  import eth_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);
  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init)
      crc_d = CRC_INIT;
    else if (en)
      crc_d = crc32_step(crc_q, data);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      crc_q <= CRC_INIT;
    else
      crc_q <= crc_d;
  end

  assign crc = crc_q;
endmodule

// File: rtl/gmii_udp_rx.sv
// gmii_udp_rx: GMII frame parser that filters UDP traffic to this board,
// streams the payload and reports FCS status plus a host command byte.
module gmii_udp_rx
  import eth_rx_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC   = 48'h000A_3501_0203,
  parameter logic [15:0] LOCAL_PORT  = 16'd8080,
  parameter int          MAX_PAYLOAD = 1472
) (
  input  logic       e_rxc,
  input  logic       rst_n,
  input  logic       e_rxdv,
  input  logic       e_rxer,
  input  logic [7:0] e_rxd,
  output logic [7:0] pl_data,
  output logic       pl_valid,
  output logic       pl_first,
  output logic       pl_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [7:0] cmd_code,
  output logic       cmd_valid
);
  localparam logic [10:0] ETH_LAST = 11'(ETH_HDR_LEN - 1);
  localparam logic [10:0] IP_LAST  = 11'(IP_HDR_LEN - 1);
  localparam logic [10:0] UDP_LAST = 11'(UDP_HDR_LEN - 1);
  localparam logic [15:0] UDP_MIN  = 16'(UDP_HDR_LEN + 1);
  localparam logic [15:0] UDP_MAX  = 16'(UDP_HDR_LEN + MAX_PAYLOAD);

  rx_state_e   state_q, state_d;
  logic [10:0] cnt_q, cnt_d, pl_len_q, pl_len_d;
  logic [7:0]  len_hi_q, len_hi_d, cmd_pend_q, cmd_pend_d;
  logic [7:0]  cmd_code_q, cmd_code_d, pl_data_q, pl_data_d;
  logic        uc_q, uc_d, bc_q, bc_d, err_q, err_d;
  logic        armed_q, armed_d;
  logic        pl_valid_q, pl_valid_d, pl_first_q, pl_first_d;
  logic        pl_last_q, pl_last_d;
  logic        frame_ok_q, frame_ok_d, frame_err_q, frame_err_d;
  logic        crc_init, crc_en;
  logic [31:0] crc;
  logic        in_frame, sfd, hit_uc, hit_bc, hdr_bad, pl_end;
  logic [47:0] mac_sh;
  logic [15:0] udp_len;

  crc32_d8 u_crc (
    .clk  (e_rxc),
    .rst_n(rst_n),
    .init (crc_init),
    .en   (crc_en),
    .data (e_rxd),
    .crc  (crc)
  );

  assign in_frame = state_q inside {ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, TAIL};
  assign sfd      = (state_q == PREAMBLE) && e_rxdv && (e_rxd == SFD_BYTE);
  assign mac_sh   = LOCAL_MAC << {cnt_q[2:0], 3'b000};
  assign hit_uc   = uc_q && (e_rxd == mac_sh[47:40]);
  assign hit_bc   = bc_q && (e_rxd == 8'hFF);
  assign udp_len  = {len_hi_q, e_rxd};
  assign pl_end   = cnt_q == pl_len_q - 11'd1;

  always_comb begin
    hdr_bad = 1'b0;
    unique case (state_q)
      ETH_HDR:
        if (cnt_q < 11'd6)
          hdr_bad = !(hit_uc || hit_bc);
        else if (cnt_q == 11'd12)
          hdr_bad = e_rxd != ETHERTYPE_IPV4[15:8];
        else if (cnt_q == 11'd13)
          hdr_bad = e_rxd != ETHERTYPE_IPV4[7:0];
      IP_HDR:
        if (cnt_q == 11'd0)
          hdr_bad = e_rxd != IP_VER_IHL;
        else if (cnt_q == 11'd9)
          hdr_bad = e_rxd != IP_PROTO_UDP;
      UDP_HDR:
        if (cnt_q == 11'd2)
          hdr_bad = e_rxd != LOCAL_PORT[15:8];
        else if (cnt_q == 11'd3)
          hdr_bad = e_rxd != LOCAL_PORT[7:0];
        else if (cnt_q == 11'd5)
          hdr_bad = (udp_len < UDP_MIN) || (udp_len > UDP_MAX);
      default: hdr_bad = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (armed_q && e_rxdv && e_rxd == PREAMBLE_BYTE)
          state_d = PREAMBLE;
      PREAMBLE:
        if (!e_rxdv) state_d = IDLE;
        else if (e_rxd == SFD_BYTE) state_d = ETH_HDR;
        else if (e_rxd != PREAMBLE_BYTE) state_d = DROP;
      ETH_HDR:
        if (!e_rxdv) state_d = IDLE;
        else if (hdr_bad) state_d = DROP;
        else if (cnt_q == ETH_LAST) state_d = IP_HDR;
      IP_HDR:
        if (!e_rxdv) state_d = IDLE;
        else if (hdr_bad) state_d = DROP;
        else if (cnt_q == IP_LAST) state_d = UDP_HDR;
      UDP_HDR:
        if (!e_rxdv) state_d = IDLE;
        else if (hdr_bad) state_d = DROP;
        else if (cnt_q == UDP_LAST) state_d = PAYLOAD;
      PAYLOAD:
        if (!e_rxdv) state_d = IDLE;
        else if (pl_end) state_d = TAIL;
      TAIL, DROP:
        if (!e_rxdv) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    pl_len_d    = pl_len_q;
    len_hi_d    = len_hi_q;
    cmd_pend_d  = cmd_pend_q;
    cmd_code_d  = cmd_code_q;
    uc_d        = uc_q;
    bc_d        = bc_q;
    err_d       = err_q | (in_frame & e_rxdv & e_rxer);
    // after reset, never lock onto a frame already in flight
    armed_d     = armed_q | ~e_rxdv;
    pl_data_d   = 8'h00;
    pl_valid_d  = 1'b0;
    pl_first_d  = 1'b0;
    pl_last_d   = 1'b0;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    crc_init    = sfd;
    crc_en      = in_frame & e_rxdv;
    if (sfd) begin
      cnt_d = 11'd0;
      uc_d  = 1'b1;
      bc_d  = 1'b1;
      err_d = 1'b0;
    end
    if (e_rxdv) begin
      unique case (state_q)
        ETH_HDR: begin
          cnt_d = (cnt_q == ETH_LAST) ? 11'd0 : cnt_q + 11'd1;
          uc_d  = hit_uc;
          bc_d  = hit_bc;
        end
        IP_HDR:
          cnt_d = (cnt_q == IP_LAST) ? 11'd0 : cnt_q + 11'd1;
        UDP_HDR: begin
          cnt_d = (cnt_q == UDP_LAST) ? 11'd0 : cnt_q + 11'd1;
          if (cnt_q == 11'd4)
            len_hi_d = e_rxd;
          if (cnt_q == 11'd5)
            pl_len_d = 11'(udp_len - 16'(UDP_HDR_LEN));
        end
        PAYLOAD: begin
          pl_valid_d = 1'b1;
          pl_data_d  = e_rxd;
          pl_first_d = cnt_q == 11'd0;
          pl_last_d  = pl_end;
          cnt_d      = cnt_q + 11'd1;
          if (cnt_q == 11'd0)
            cmd_pend_d = e_rxd;
        end
        default: ;
      endcase
    end else if (state_q == PAYLOAD) begin
      frame_err_d = 1'b1;
    end else if (state_q == TAIL) begin
      if (crc == CRC_RESIDUE && !err_q) begin
        frame_ok_d = 1'b1;
        cmd_code_d = cmd_pend_q;
      end else begin
        frame_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge e_rxc or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 11'd0;
      pl_len_q    <= 11'd0;
      len_hi_q    <= 8'h00;
      cmd_pend_q  <= 8'h00;
      cmd_code_q  <= 8'h00;
      uc_q        <= 1'b0;
      bc_q        <= 1'b0;
      err_q       <= 1'b0;
      armed_q     <= 1'b0;
      pl_data_q   <= 8'h00;
      pl_valid_q  <= 1'b0;
      pl_first_q  <= 1'b0;
      pl_last_q   <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pl_len_q    <= pl_len_d;
      len_hi_q    <= len_hi_d;
      cmd_pend_q  <= cmd_pend_d;
      cmd_code_q  <= cmd_code_d;
      uc_q        <= uc_d;
      bc_q        <= bc_d;
      err_q       <= err_d;
      armed_q     <= armed_d;
      pl_data_q   <= pl_data_d;
      pl_valid_q  <= pl_valid_d;
      pl_first_q  <= pl_first_d;
      pl_last_q   <= pl_last_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign pl_data   = pl_data_q;
  assign pl_valid  = pl_valid_q;
  assign pl_first  = pl_first_q;
  assign pl_last   = pl_last_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign cmd_code  = cmd_code_q;
  assign cmd_valid = frame_ok_q;
endmodule
